// File: rtl/pwm_pkg.sv
// Shared types and constants for the dead-time gate driver.
// Latency: n/a; backpressure: n/a.
package pwm_pkg;

    localparam int DEAD_W_DEF = 8;

    // Bit positions of the one-hot state register
    localparam int S_IDLE_B    = 0;
    localparam int S_DT_RISE_B = 1;
    localparam int S_HS_ON_B   = 2;
    localparam int S_DT_FALL_B = 3;
    localparam int S_LS_ON_B   = 4;
    localparam int S_FAULT_B   = 5;

    localparam logic [5:0] OH_IDLE    = 6'b000001;
    localparam logic [5:0] OH_DT_RISE = 6'b000010;
    localparam logic [5:0] OH_HS_ON   = 6'b000100;
    localparam logic [5:0] OH_DT_FALL = 6'b001000;
    localparam logic [5:0] OH_LS_ON   = 6'b010000;
    localparam logic [5:0] OH_FAULT   = 6'b100000;

    typedef enum logic [5:0] {
        IDLE    = OH_IDLE,
        DT_RISE = OH_DT_RISE,
        HS_ON   = OH_HS_ON,
        DT_FALL = OH_DT_FALL,
        LS_ON   = OH_LS_ON,
        FAULT   = OH_FAULT
    } pwm_dt_state_t;

endpackage

// File: rtl/pwm_dead_counter.sv
// Loadable saturating down-counter timing the dead interval; zero flag is registered-state decode.
// Latency: load/dec visible one cycle later; backpressure: none.
module pwm_dead_counter
    import pwm_pkg::*;
#(
    parameter int DEAD_W = DEAD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              dec,
    input  logic [DEAD_W-1:0] load_val,
    output logic              zero
);

    localparam logic [DEAD_W-1:0] ONE = DEAD_W'(1);

    logic [DEAD_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with programmable dead time, enable and latched fault shutdown.
// Latency: gate drops 1 cycle after pwm_in is sampled, opposite gate rises d+2 after; backpressure: none.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEAD_W = DEAD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              pwm_in,
    input  logic [DEAD_W-1:0] dead_rise,
    input  logic [DEAD_W-1:0] dead_fall,
    input  logic              fault,
    input  logic              fault_clr,
    output logic              hs_out,
    output logic              ls_out,
    output logic              dt_active,
    output logic              fault_active
);

    pwm_dt_state_t     state;
    logic              cnt_load;
    logic              cnt_dec;
    logic [DEAD_W-1:0] cnt_val;
    logic              cnt_zero;

    // Counter control mirrors the FSM's normal-switching branch; reset, fault
    // and disable all leave the count alone since IDLE/FAULT never read it.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = dead_rise;
        if (!reset && !fault && en) begin
            case (state)
                IDLE: begin
                    cnt_load = 1'b1;
                    cnt_val  = pwm_in ? dead_rise : dead_fall;
                end
                DT_RISE: begin
                    if (!pwm_in) begin
                        cnt_load = 1'b1;
                        cnt_val  = dead_fall;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                DT_FALL: begin
                    if (pwm_in) begin
                        cnt_load = 1'b1;
                        cnt_val  = dead_rise;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                HS_ON: begin
                    cnt_load = !pwm_in;
                    cnt_val  = dead_fall;
                end
                LS_ON: begin
                    cnt_load = pwm_in;
                    cnt_val  = dead_rise;
                end
                default: begin
                    cnt_load = 1'b0;
                end
            endcase
        end
    end

    pwm_dead_counter #(
        .DEAD_W (DEAD_W)
    ) u_dead_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (fault) begin
            state <= FAULT;
        end else if (state == FAULT) begin
            if (fault_clr) begin
                state <= IDLE;
            end
        end else if (!en) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= pwm_in ? DT_RISE : DT_FALL;
                DT_RISE: begin
                    if (!pwm_in) begin
                        state <= DT_FALL;
                    end else if (cnt_zero) begin
                        state <= HS_ON;
                    end
                end
                DT_FALL: begin
                    if (pwm_in) begin
                        state <= DT_RISE;
                    end else if (cnt_zero) begin
                        state <= LS_ON;
                    end
                end
                HS_ON: begin
                    if (!pwm_in) begin
                        state <= DT_FALL;
                    end
                end
                LS_ON: begin
                    if (pwm_in) begin
                        state <= DT_RISE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Each output is a single state flop, so the gates can never overlap.
    assign hs_out       = state[S_HS_ON_B];
    assign ls_out       = state[S_LS_ON_B];
    assign dt_active    = state[S_DT_RISE_B] | state[S_DT_FALL_B];
    assign fault_active = state[S_FAULT_B];

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: directed segments with hand-derived gate states, then random traffic.
module tb_pwm_deadtime;

    localparam logic [3:0] E_OFF = 4'b0000;
    localparam logic [3:0] E_HS  = 4'b1000;
    localparam logic [3:0] E_LS  = 4'b0100;
    localparam logic [3:0] E_DT  = 4'b0010;
    localparam logic [3:0] E_FA  = 4'b0001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] dead_rise = 8'd4;
    logic [7:0] dead_fall = 8'd4;
    logic       fault = 1'b0;
    logic       fault_clr = 1'b0;
    logic       hs_out, ls_out, dt_active, fault_active;

    typedef struct {
        logic [3:0] e;
        int         seg;
    } exp_t;

    exp_t       sbq[$];
    exp_t       x;
    logic [3:0] got;
    int         total = 0;
    int         passed = 0;
    int         seg_id = 0;
    int         gap_hs = 1;
    int         gap_ls = 1;
    int         off_run = 0;
    logic       prev_hs = 1'b0;
    logic       prev_ls = 1'b0;

    pwm_deadtime #(.DEAD_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .pwm_in       (pwm_in),
        .dead_rise    (dead_rise),
        .dead_fall    (dead_fall),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .hs_out       (hs_out),
        .ls_out       (ls_out),
        .dt_active    (dt_active),
        .fault_active (fault_active)
    );

    always #5 clk = ~clk;

    // n cycles of constant inputs, expecting {hs,ls,dt,fault} == ex after each edge
    task automatic seg(input int n, input logic p, input logic e_n, input logic f,
                       input logic clr, input logic r, input logic [7:0] dr,
                       input logic [7:0] df, input logic [3:0] ex);
        exp_t item;
        seg_id++;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = r; en = e_n; pwm_in = p; fault = f; fault_clr = clr;
            dead_rise = dr; dead_fall = df;
            item.e = ex;
            item.seg = seg_id;
            sbq.push_back(item);
        end
    endtask

    // Monitor: scoreboard pops plus per-cycle safety properties
    initial begin
        forever begin
            @(posedge clk);
            #1;
            got = {hs_out, ls_out, dt_active, fault_active};
            total++;
            if (hs_out && ls_out) $display("FAIL overlap hs=%b ls=%b want not both 1", hs_out, ls_out);
            else passed++;
            if (hs_out && !prev_hs) begin
                total++;
                if (off_run >= gap_hs) passed++;
                else $display("FAIL hs_gap off_run=%0d want >=%0d", off_run, gap_hs);
            end
            if (ls_out && !prev_ls) begin
                total++;
                if (off_run >= gap_ls) passed++;
                else $display("FAIL ls_gap off_run=%0d want >=%0d", off_run, gap_ls);
            end
            if (!hs_out && !ls_out) off_run++;
            else off_run = 0;
            prev_hs = hs_out;
            prev_ls = ls_out;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                total++;
                if (got === x.e) passed++;
                else $display("FAIL seg%0d {hs,ls,dt,fa} got %b want %b", x.seg, got, x.e);
            end
        end
    end

    initial begin
        int run;
        // reset, then idle while disabled
        seg(2, 0, 0, 0, 0, 1, 4, 4, E_OFF);
        seg(2, 0, 0, 0, 0, 0, 4, 4, E_OFF);
        // first conduction always preceded by a dead interval
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(10, 0, 1, 0, 0, 0, 4, 4, E_LS);
        // 100-cycle period, 80% duty, d=4: 75 HS / 15 LS
        for (int p = 0; p < 2; p++) begin
            seg(5, 1, 1, 0, 0, 0, 4, 4, E_DT);
            seg(75, 1, 1, 0, 0, 0, 4, 4, E_HS);
            seg(5, 0, 1, 0, 0, 0, 4, 4, E_DT);
            seg(15, 0, 1, 0, 0, 0, 4, 4, E_LS);
        end
        // dead_rise=0 still gives one off cycle
        seg(1, 1, 1, 0, 0, 0, 0, 4, E_DT);
        seg(3, 1, 1, 0, 0, 0, 0, 4, E_HS);
        seg(5, 0, 1, 0, 0, 0, 0, 4, E_DT);
        seg(5, 0, 1, 0, 0, 0, 0, 4, E_LS);
        // 3-cycle pulse against dead_rise=10: aborted, HS never asserts
        seg(3, 1, 1, 0, 0, 0, 10, 4, E_DT);
        seg(5, 0, 1, 0, 0, 0, 10, 4, E_DT);
        seg(5, 0, 1, 0, 0, 0, 10, 4, E_LS);
        // L = d+1 swallowed; L = d+2 gives a 1-cycle gate pulse
        seg(5, 1, 1, 0, 0, 0, 4, 4, E_DT);
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(3, 0, 1, 0, 0, 0, 4, 4, E_LS);
        seg(5, 1, 1, 0, 0, 0, 4, 4, E_DT);
        seg(1, 1, 1, 0, 0, 0, 4, 4, E_HS);
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(3, 0, 1, 0, 0, 0, 4, 4, E_LS);
        // dead value changed mid-count: running count not reloaded
        seg(2, 1, 1, 0, 0, 0, 4, 4, E_DT);
        seg(3, 1, 1, 0, 0, 0, 0, 4, E_DT);
        seg(2, 1, 1, 0, 0, 0, 0, 4, E_HS);
        seg(3, 0, 1, 0, 0, 0, 0, 2, E_DT);
        seg(2, 0, 1, 0, 0, 0, 0, 2, E_LS);
        // maximum dead value
        seg(256, 1, 1, 0, 0, 0, 255, 4, E_DT);
        seg(2, 1, 1, 0, 0, 0, 255, 4, E_HS);
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_LS);
        // disable mid-conduction, then re-enable
        seg(4, 0, 0, 0, 0, 0, 4, 4, E_OFF);
        seg(5, 1, 1, 0, 0, 0, 4, 4, E_DT);
        seg(5, 1, 1, 0, 0, 0, 4, 4, E_HS);
        // fault in HS_ON: latched, clr ignored while fault=1, en ignored
        seg(1, 1, 1, 1, 0, 0, 4, 4, E_FA);
        seg(1, 1, 1, 1, 1, 0, 4, 4, E_FA);
        seg(2, 1, 0, 0, 0, 0, 4, 4, E_FA);
        seg(2, 1, 1, 0, 0, 0, 4, 4, E_FA);
        seg(1, 1, 1, 0, 1, 0, 4, 4, E_OFF);
        seg(5, 1, 1, 0, 0, 0, 4, 4, E_DT);
        seg(5, 1, 1, 0, 0, 0, 4, 4, E_HS);
        // fault during a dead interval
        seg(2, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(1, 0, 1, 1, 0, 0, 4, 4, E_FA);
        seg(1, 0, 1, 0, 1, 0, 4, 4, E_OFF);
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(3, 0, 1, 0, 0, 0, 4, 4, E_LS);
        // reset outranks fault
        seg(1, 0, 1, 1, 0, 1, 4, 4, E_OFF);
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(3, 0, 1, 0, 0, 0, 4, 4, E_LS);
        // reset in DT_FALL with cnt=3
        seg(5, 1, 1, 0, 0, 0, 4, 4, E_DT);
        seg(3, 1, 1, 0, 0, 0, 4, 4, E_HS);
        seg(2, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(1, 0, 1, 0, 0, 1, 4, 4, E_OFF);
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_LS);
        // reset mid-conduction
        seg(1, 0, 1, 0, 0, 1, 4, 4, E_OFF);
        seg(5, 0, 1, 0, 0, 0, 4, 4, E_DT);
        seg(2, 0, 1, 0, 0, 0, 4, 4, E_LS);

        // random traffic, dead values fixed per chunk and changed only while disabled
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            en = 1'b0; fault = 1'b0; fault_clr = 1'b0; reset = 1'b0;
            dead_rise = 8'($urandom_range(0, 12));
            dead_fall = 8'($urandom_range(0, 12));
            gap_hs = int'(dead_rise) + 1;
            gap_ls = int'(dead_fall) + 1;
            run = 0;
            for (int i = 0; i < 499; i++) begin
                @(negedge clk);
                if (run == 0) begin
                    pwm_in = ~pwm_in;
                    run = int'($urandom_range(1, 30));
                end
                run--;
                en = ($urandom_range(0, 199) != 0);
                fault = ($urandom_range(0, 299) == 0);
                fault_clr = ($urandom_range(0, 19) == 0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sbq.size() == 0) passed++;
        else $display("FAIL scoreboard_drain left=%0d want 0", sbq.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Downstream stage of the PWM generator. Takes its single-ended `pwm` output and drives a complementary high-side/low-side gate pair.
- Inserts a programmable dead time on every edge so the two gate outputs are never high together.
- Adds an enable and a latched fault shutdown.
- Everything sits in the same `clk` domain as the PWM generator, so no input synchronizer is needed.

Parameters:
- DEAD_W, 8, width of the dead-time configuration inputs and the internal down-counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  1 = normal switching; 0 = both outputs off.
- pwm_in  in  1  PWM from the upstream generator, same clock domain, registered upstream.
- dead_rise  in  DEAD_W  dead-time count before hs_out turns on; sampled on entry to DT_RISE.
- dead_fall  in  DEAD_W  dead-time count before ls_out turns on; sampled on entry to DT_FALL.
- fault  in  1  synchronous shutdown request, level-sensitive.
- fault_clr  in  1  releases the latched fault; honoured only while fault=0.
- hs_out  out  1  high-side gate.
- ls_out  out  1  low-side gate.
- dt_active  out  1  high while in DT_RISE or DT_FALL.
- fault_active  out  1  high while in FAULT.

Behaviour:
- Reset (synchronous): state=IDLE, cnt=0. All outputs are 0 at the first edge with reset=1.
- Outputs are decoded directly from registered one-hot state flops. No combinational path from any input to any output.
- Invariant: hs_out & ls_out == 0 in every cycle, including reset, fault and mid-dead-time aborts.
- States and their outputs:
  - IDLE: hs_out=0, ls_out=0.
  - DT_RISE: both outputs 0, dt_active=1.
  - HS_ON: hs_out=1.
  - DT_FALL: both outputs 0, dt_active=1.
  - LS_ON: ls_out=1.
  - FAULT: both outputs 0, fault_active=1.
- Transition priority each edge: reset > fault > ~en > normal transitions.
- fault=1 in any state: next state is FAULT, and both outputs are 0 from the next edge.
- FAULT exits to IDLE only when fault=0 and fault_clr=1 on the same edge. Otherwise FAULT holds; en has no effect while in FAULT.
- en=0 in any non-FAULT state: next state is IDLE. cnt is not relevant in IDLE.
- IDLE with en=1:
  - pwm_in=1: go to DT_RISE, cnt<=dead_rise.
  - pwm_in=0: go to DT_FALL, cnt<=dead_fall.
  - A dead interval always precedes first conduction.
- DT_RISE:
  - pwm_in=0: go to DT_FALL, cnt<=dead_fall (abort).
  - Else if cnt==0: go to HS_ON.
  - Else cnt<=cnt-1.
- DT_FALL is symmetric: abort to DT_RISE when pwm_in=1, go to LS_ON when cnt==0.
- HS_ON: pwm_in=0 goes to DT_FALL, cnt<=dead_fall.
- LS_ON: pwm_in=1 goes to DT_RISE, cnt<=dead_rise.
- Timing (pwm_in changes at edge k):
  - The conducting output drops at edge k+1.
  - The opposite output rises at edge k+d+2, where d is the sampled dead value.
  - Both-off interval = d+1 cycles; d=0 still gives 1 cycle.
- Pulse narrowing: a pwm_in pulse of L cycles gives a gate pulse of L-(d+1) cycles. If L ≤ d+1 the gate never asserts.
- dead_rise/dead_fall changes take effect only at the next dead-interval entry. A running count is never reloaded except on an abort.
- cnt is a DEAD_W-bit unsigned down-counter; it never decrements below 0 and does not wrap.
- Reset asserted mid dead-time or mid conduction: both outputs 0 on the next edge. After release the block re-enters via IDLE.

Decomposition:
- Shared package pwm_pkg holds:
  - the state enum typedef pwm_dt_state_t (IDLE, DT_RISE, HS_ON, DT_FALL, LS_ON, FAULT);
  - the DEAD_W default constant;
  - the one-hot encoding constants.
- One sub-module: pwm_dead_counter, a loadable DEAD_W down-counter with load, dec and zero flag.
- The FSM stays in pwm_deadtime.

Test Plan:
1. PWM generator (PERIOD=100, DUTY_CYCLE=80) feeding pwm_in, en=1, dead_rise=dead_fall=4 → hs_out high 75 cycles and ls_out high 15 cycles per 100-cycle period, never overlapping; dt_active high 5 cycles after each edge.
2. dead_rise=0, pwm_in steps 0→1 at edge k → ls_out falls at k+1, hs_out rises at k+2.
3. dead_rise=10, 3-cycle pwm_in high pulse during LS_ON → hs_out stays 0; state goes DT_RISE→DT_FALL; ls_out reasserts 5 cycles after pwm_in falls (dead_fall=4).
4. fault=1 for one cycle during HS_ON → both outputs 0 next edge and fault_active=1. fault_clr=1 while fault=1 → still FAULT. fault=0 with fault_clr=1 → IDLE, then dead interval, then resumes.
5. reset pulsed in DT_FALL with cnt=3 → all outputs 0 next edge. After release with en=1, pwm_in=0 → ls_out rises after dead_fall+1 cycles.
6. Random pwm_in/en/fault/dead values for 10k cycles → hs_out & ls_out never both 1; a both-off gap of at least d+1 cycles precedes every output rise.
